// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared multiply/divide constants, FSM state and Booth digit encodings.
// No ports. Provides MUL_W, STEPS, RESULT_W, the HI/LO split of the 64-bit result,
// state_t, digit_t and the booth_digit() window decoder.
package mul_div_pkg;
    localparam int MUL_W    = 32;
    localparam int STEPS    = MUL_W / 2;
    localparam int RESULT_W = 2 * MUL_W;
    localparam int HI_MSB   = RESULT_W - 1;
    localparam int HI_LSB   = MUL_W;
    localparam int LO_MSB   = MUL_W - 1;
    localparam int LO_LSB   = 0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} digit_t;

    // Radix-4 Booth recoding of the window {Q[1], Q[0], q_m1}.
    function automatic digit_t booth_digit(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return POS1;
            3'b011:         return POS2;
            3'b100:         return NEG2;
            3'b101, 3'b110: return NEG1;
            default:        return ZERO;
        endcase
    endfunction
endpackage

// File: rtl/booth_pp_sel.sv
// booth_pp_sel: selects the radix-4 Booth partial product for one step.
// Ports: win  - 3-bit window {Q[1], Q[0], q_m1}
//        m    - sign-extended multiplicand, WIDTH+2 bits
//        pp   - partial product 0, +-M or +-2M, WIDTH+2 bits
module booth_pp_sel
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic [2:0]       win,
    input  logic [WIDTH+1:0] m,
    output logic [WIDTH+1:0] pp
);
    digit_t d;
    logic [WIDTH+1:0] m2;

    assign d  = booth_digit(win);
    assign m2 = m << 1;
    assign pp = d == POS1 ? m :
                d == POS2 ? m2 :
                d == NEG1 ? -m :
                d == NEG2 ? -m2 : '0;
endmodule

// File: rtl/seq_booth_mul.sv
// seq_booth_mul: sequential signed WIDTHxWIDTH radix-4 Booth multiplier, WIDTH/2 steps.
// Ports: clock - rising-edge clock
//        clear - asynchronous active-low reset
//        start - request, sampled only in IDLE
//        A, B  - signed multiplicand / multiplier, sampled on the accepting edge
//        busy  - high in RUN and DONE
//        done  - one-cycle pulse while C has just been updated
//        C     - signed 2*WIDTH product (upper half -> HI, lower half -> LO)
module seq_booth_mul
    import mul_div_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   C
);
    localparam int CW = $clog2(WIDTH);

    state_t state, state_n;
    logic [WIDTH+1:0] m, acc, pp, sum, acc_n;
    logic [WIDTH-1:0] q, q_n;
    logic             q_m1, last;
    logic [CW-1:0]    cnt;

    booth_pp_sel #(.WIDTH(WIDTH)) u_pp (
        .win (({q[1:0], q_m1})),
        .m   (m),
        .pp  (pp)
    );

    // Add the partial product, then arithmetic-shift {acc, Q, q_m1} right by two.
    assign sum   = acc + pp;
    assign acc_n = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    assign q_n   = {sum[1:0], q[WIDTH-1:2]};
    assign last  = cnt == CW'(WIDTH / 2 - 1);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = IDLE;
        busy    = 1'b0;
        done    = 1'b0;
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) : IDLE;
        busy    = state != IDLE;
        done    = state == DONE;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            m    <= '0;
            acc  <= '0;
            q    <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
            C    <= '0;
        end else if (state == IDLE && start) begin
            m    <= {{2{A[WIDTH-1]}}, A};
            acc  <= '0;
            q    <= B;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            acc  <= acc_n;
            q    <= q_n;
            q_m1 <= q[1];
            cnt  <= cnt + 1'b1;
            if (last) C <= {acc_n[WIDTH-1:0], q_n};
        end
    end
endmodule

// File: tb/tb_seq_booth_mul.sv
// tb_seq_booth_mul: scoreboard bench for seq_booth_mul (directed vectors plus back-to-back stream).
module tb_seq_booth_mul;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done;
    logic [63:0] C;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done = -1;
    bit b2b = 1'b0;
    logic [63:0] sb[$];

    seq_booth_mul dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .C     (C)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected product.
    always @(negedge clock) begin
        if (clear && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got C=%h expected no done (cycle %0d)", C, cyc);
            end else begin
                check("product", C, sb.pop_front());
            end
            if (b2b && last_done >= 0) check("b2b_spacing", 64'(cyc - last_done), 64'd18);
            last_done = cyc;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clock);
        check("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    // One operation with cycle-exact busy/done checks after each edge k+i.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(negedge clock);
        A = a;
        B = b;
        start = 1'b1;
        sb.push_back(exp);
        @(posedge clock);
        #1;
        start = 1'b0;
        A = ~a;
        B = a ^ b;
        for (int i = 0; i <= 17; i++) begin
            if (i > 0) @(negedge clock);
            else @(negedge clock);
            check("done_timing", {63'b0, done}, {63'b0, i == 16});
            check("busy_timing", {63'b0, busy}, {63'b0, i <= 16});
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8] = '{
        '{32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB},
        '{32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000},
        '{32'h8000_0000,  32'd1,         64'hFFFF_FFFF_8000_0000},
        '{32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001},
        '{32'h7FFF_FFFF,  32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001},
        '{32'h8000_0000,  32'h7FFF_FFFF, 64'hC000_0000_8000_0000},
        '{32'hFFFF_FFFF,  32'h8000_0000, 64'h0000_0000_8000_0000},
        '{32'd0,          32'h1234_5678, 64'h0000_0000_0000_0000}
    };

    initial begin
        logic signed [31:0] ra, rb;
        logic signed [63:0] rp;
        #2;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_C", C, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("idle_busy", {63'b0, busy}, 64'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

        // start during RUN is ignored, inputs changed afterwards
        @(negedge clock);
        A = 32'd7;
        B = 32'd3;
        start = 1'b1;
        sb.push_back(64'd21);
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        A = 32'd2;
        B = 32'd2;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        A = 32'd9;
        B = 32'd9;
        wait_idle();
        repeat (3) @(negedge clock);
        check("ignored_start_hold", C, 64'd21);
        check("ignored_start_busy", {63'b0, busy}, 64'd0);

        // clear mid-operation abandons it
        @(negedge clock);
        A = 32'd5;
        B = 32'd5;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (8) @(posedge clock);
        #2 clear = 1'b0;
        #1;
        check("clear_busy", {63'b0, busy}, 64'd0);
        check("clear_done", {63'b0, done}, 64'd0);
        check("clear_C", C, 64'd0);
        @(negedge clock);
        clear = 1'b1;
        run_op(32'd5, 32'd5, 64'd25);

        // start held high: one operation every 18 cycles
        b2b = 1'b1;
        last_done = -1;
        @(negedge clock);
        start = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            rp = ra * rb;
            A = ra;
            B = rb;
            sb.push_back(rp);
            @(posedge clock);
            #1;
            if (n == 999) start = 1'b0;
            A = $urandom;
            B = $urandom;
            if (n < 999) repeat (17) @(posedge clock);
        end
        wait_idle();
        repeat (2) @(negedge clock);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish by 400000");
        $fatal(1);
    end
endmodule

// File: doc/seq_booth_mul.md
# seq_booth_mul

Sequential signed 32×32 multiplier for the datapath's MUL instruction. It is the multiply counterpart of the combinational divider and uses the same 64-bit result packing: C[63:32] is written to HI and C[31:0] to LO. It uses radix-4 Booth recoding over 16 iterations with a start/done handshake driven by the control unit. It replaces a combinational multiply so the multiplier is not on the ALU critical path.

## Interface
- WIDTH, 32, operand width; must be even; product is 2*WIDTH bits.
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  multiplicand, two's complement.
- B  in  WIDTH  multiplier, two's complement.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse when C is updated.
- C  out  2*WIDTH  signed product; C[63:32] goes to HI, C[31:0] goes to LO.

## Operation
- States:
  - IDLE: start=1 latches A into M (sign-extended to WIDTH+2 bits). It loads acc=0, Q=B, q_m1=0 and cnt=0, then goes to RUN. start=0 stays in IDLE.
  - RUN: performs one Booth step per cycle with cnt++. After step WIDTH/2 (cnt==WIDTH/2-1), goes to DONE.
  - DONE: goes to IDLE unconditionally.
- Booth step: the digit is taken from {Q[1], Q[0], q_m1}.
  - 000, 111 → 0
  - 001, 010 → +M
  - 011 → +2M
  - 100 → -2M
  - 101, 110 → -M
- Arithmetic:
  - acc = acc + pp in WIDTH+2 bits; two's complement negation; overflow discarded.
  - Then {acc, Q, q_m1} is arithmetic-shifted right by 2, replicating acc's MSB.
- Result: on the RUN→DONE edge, C <= {acc[WIDTH-1:0], Q} after the final shift, and done is set to 1. C holds until the next completion.
- Width: a 34-bit acc is required so that ±2M with M = -2^31 does not overflow.
- Boundary and error cases:
  - start while busy (RUN or DONE) is ignored; no queuing.
  - A and B are sampled only on the accepting edge and may change freely afterwards.
  - clear low at any time forces IDLE, acc=0, Q=0, cnt=0, C=0, done=0, busy=0. An in-flight operation is abandoned and C is not updated.
  - start held high continuously gives back-to-back operations, one every WIDTH/2+2 cycles.

## Timing
- Reset values: busy=0, done=0, C=0.
- Start accepted at edge k: busy=1 from k. Steps run at edges k+1 … k+16. At edge k+16, C becomes valid and done=1.
- At edge k+17: done=0, busy=0 (IDLE). The earliest next acceptance is edge k+18.
- Latency: 16 cycles from the accepting edge to the result (WIDTH/2 in general). Throughput: one operation per 18 cycles.
- done is exactly one cycle wide. C is stable whenever done=1 and in all states thereafter until the next done.

## Structure
- Shared package (mul_div_pkg): state encoding, Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2), STEPS = WIDTH/2, RESULT_W = 2*WIDTH.
  - The divider's future sequential version reuses RESULT_W and the HI/LO split constants from this package.
- One combinational sub-module, booth_pp_sel: inputs are the 3-bit window and M; the output is the WIDTH+2-bit partial product.
- Top module: FSM, counter, acc/Q/q_m1 registers and C register.

## Test plan
- A=7, B=-3, start pulse at edge k → C=0xFFFF_FFFF_FFFF_FFEB, done=1 only during the cycle after edge k+16, busy falls at k+17.
- A=0x8000_0000, B=0x8000_0000 → C=0x4000_0000_0000_0000; A=0x8000_0000, B=1 → C=0xFFFF_FFFF_8000_0000.
- A=0xFFFF_FFFF, B=0xFFFF_FFFF → C=1; A=0x7FFF_FFFF, B=0x7FFF_FFFF → C=0x3FFF_FFFF_0000_0001.
- Start 7×3; at k+5 pulse start with A=2, B=2 and change the A/B inputs → second start ignored, C=21, only one done pulse.
- Start 5×5; drive clear low at k+8 → busy=0, done=0 and C=0 immediately. Restart with 5×5 → C=25 after 16 cycles.
- start held high with random signed pairs (≥1000) → done pulses every 18 cycles, and each C matches the 64-bit signed reference product.
